alu_input_conditioner: RTL and testbench
========================================

Name: alu_input_conditioner

Overview:
- Front-end stage directly upstream of ALU_top. Drives ALU_top's BUTTONS and SWITCHES inputs.
- Synchronises the raw board push-buttons and slide switches, debounces each button, and turns each debounced press into a single-cycle strobe.
- Captures a switch snapshot with each strobe, so ALU_top sees exactly one clean load per physical press (DATOA / DATOB / OPCODE).

Parameters:
- N_BUTTONS, 3, number of push-buttons; bit 0 = DATOA, bit 1 = DATOB, bit 2 = OPCODE.
- SIZEDATA, 8, switch / data width.
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a level change. Use 4 in simulation and 1_000_000 on board. Minimum 1.
- CNT_WIDTH, 20, debounce counter width. Must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- SWITCHES_RAW  input  SIZEDATA  raw slide switches, asynchronous to CLK.
- BUTTONS_RAW  input  N_BUTTONS  raw push-buttons, asynchronous to CLK, active-high, bouncing.
- BUTTONS  output  N_BUTTONS  one-hot, single-cycle press strobe; feeds ALU_top BUTTONS.
- SWITCHES  output  SIZEDATA  switch snapshot taken with the last strobe; feeds ALU_top SWITCHES.
- BTN_LEVEL  output  N_BUTTONS  debounced button levels, for status LEDs.

Behaviour:
- Reset (RST_N low, asynchronous):
  - BUTTONS = 0, SWITCHES = 0, BTN_LEVEL = 0.
  - All synchroniser flops, counters and stable states = 0.
  - Reset has immediate effect, including mid-count or mid-strobe. Any in-progress count is discarded.
- Synchronisation:
  - Each BUTTONS_RAW and SWITCHES_RAW bit passes through a 2-flop synchroniser. The synchronised value is s.
- Debounce (per button i), stable state d[i] = BTN_LEVEL[i]:
  - If s[i] == d[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: d[i] <= s[i], cnt[i] <= 0 (accept).
  - Else: cnt[i] <= cnt[i]+1.
  - Any cycle with s[i] == d[i] restarts the count. A glitch shorter than DEBOUNCE_CYCLES synchronised cycles is ignored.
- Rise event:
  - rise[i] is true on the edge where d[i] transitions 0->1.
  - Release (1->0) produces no strobe.
- Strobe generation (registered, same edge as the d update):
  - If any rise[i] is true: BUTTONS <= one-hot of the lowest index i with rise[i], and SWITCHES <= synchronised switches.
  - Otherwise BUTTONS <= 0 and SWITCHES holds its value.
  - Simultaneous rises: lower index wins. Losing buttons still update BTN_LEVEL but never strobe for that press.
  - BUTTONS is high for exactly one cycle per accepted press, regardless of hold time.
  - Back-to-back rises on different buttons in consecutive cycles give strobes in consecutive cycles.
- Latency:
  - A raw edge that is stable from before sampling edge 1 gives BTN_LEVEL and the BUTTONS strobe high after edge DEBOUNCE_CYCLES+2.
  - With the default of 4, that is edge 6. Release is the same: BTN_LEVEL falls after edge 6.
- Data rules:
  - SWITCHES changes only on a strobe edge.
  - The value captured is the 2-flop-synchronised switches at that edge. Switch changes between presses are invisible downstream.
- No handshake back-pressure: ALU_top must consume each strobe in the cycle it is high.

Test Plan (DEBOUNCE_CYCLES=4, 10 ns clock):
- Clean press: SWITCHES_RAW=8'h5A stable, BUTTONS_RAW 000->001 just before edge 1 and held 20 cycles -> BUTTONS=001 for exactly one cycle after edge 6, SWITCHES=8'h5A from edge 6, BTN_LEVEL=001 from edge 6; no further strobe while held.
- Bounce rejection:
  - BUTTONS_RAW[1] toggles high 3 cycles / low 1 cycle for 12 cycles, then stays high -> no strobe during bouncing.
  - Single BUTTONS=010 strobe 6 cycles after the final stable high.
  - Isolated 2-cycle glitch -> no strobe, BTN_LEVEL unchanged.
- Simultaneous press: BUTTONS_RAW 000->101 in one cycle -> single strobe BUTTONS=001, BTN_LEVEL=101; BUTTONS[2] never asserts for this press.
- Full ALU sequence:
  - DATOA with switches 8'h0F, then DATOB with 8'h03, then OPCODE with 6'b100000, each press held 10 cycles and separated by 10-cycle releases.
  - Expect strobes 001, 010, 100 in order with SWITCHES 8'h0F, 8'h03, 8'h20 respectively; switch changes between presses do not alter SWITCHES.
- Release and re-press: press, release, press button 0, each phase held 10 cycles -> two separate 001 strobes; BTN_LEVEL falls 6 cycles after release.
- Reset mid-operation:
  - Assert RST_N=0 asynchronously 2 cycles into a debounce count -> all outputs 0 immediately.
  - After release, with button still held -> strobe occurs 6 edges after reset deassertion, not earlier.

Source files
------------

// File: rtl/alu_input_conditioner_if.sv
// Purpose: bundles raw board inputs and the conditioned ALU_top inputs.
// Ports  : SWITCHES_RAW/BUTTONS_RAW (board -> conditioner),
//          BUTTONS/SWITCHES/BTN_LEVEL (conditioner -> ALU_top / LEDs).
// master = board side driving raw inputs; slave = conditioner.
interface alu_input_conditioner_if #(
  parameter int N_BUTTONS = 3,
  parameter int SIZEDATA  = 8
);
  logic [SIZEDATA-1:0]  SWITCHES_RAW;
  logic [N_BUTTONS-1:0] BUTTONS_RAW;
  logic [N_BUTTONS-1:0] BUTTONS;
  logic [SIZEDATA-1:0]  SWITCHES;
  logic [N_BUTTONS-1:0] BTN_LEVEL;

  modport master (
    output SWITCHES_RAW, BUTTONS_RAW,
    input  BUTTONS, SWITCHES, BTN_LEVEL
  );

  modport slave (
    input  SWITCHES_RAW, BUTTONS_RAW,
    output BUTTONS, SWITCHES, BTN_LEVEL
  );
endinterface

// File: rtl/alu_input_conditioner.sv
// Purpose : 2-flop sync, per-button debounce, one-hot press strobe + switch snapshot for ALU_top.
// Latency : raw edge stable before edge 1 -> BTN_LEVEL and BUTTONS strobe after edge DEBOUNCE_CYCLES+2.
// Backpr. : none; each BUTTONS strobe lasts one cycle and must be consumed when high.
// Ports   : CLK, RST_N (async active-low); bus.slave carries SWITCHES_RAW/BUTTONS_RAW in,
//           BUTTONS (strobe), SWITCHES (snapshot), BTN_LEVEL (debounced levels) out.
module alu_input_conditioner #(
  parameter int N_BUTTONS       = 3,
  parameter int SIZEDATA        = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 20
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  alu_input_conditioner_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [N_BUTTONS-1:0] r_btn_meta;
  logic [N_BUTTONS-1:0] r_btn_sync;
  logic [SIZEDATA-1:0]  r_sw_meta;
  logic [SIZEDATA-1:0]  r_sw_sync;
  logic [CNT_WIDTH-1:0] r_cnt [N_BUTTONS];
  logic [N_BUTTONS-1:0] r_level;
  logic [N_BUTTONS-1:0] r_strobe;
  logic [SIZEDATA-1:0]  r_sw_snap;

  logic [N_BUTTONS-1:0] w_accept;
  logic [N_BUTTONS-1:0] w_rise;
  logic [N_BUTTONS-1:0] w_strobe_nxt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt [N_BUTTONS];

  // Debounce: count consecutive cycles where the synced input disagrees with
  // the stable level; any agreeing cycle restarts the count.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      w_cnt_nxt[i] = '0;
      if (r_btn_sync[i] != r_level[i]) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_accept[i] = 1'b1;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // An accepted change towards 1 is a press; releases never strobe.
  assign w_rise = w_accept & r_btn_sync;

  // Lowest index wins: scan downwards so the last hit overwrites.
  always_comb begin
    w_strobe_nxt = '0;
    for (int i = N_BUTTONS - 1; i >= 0; i--) begin
      if (w_rise[i]) begin
        w_strobe_nxt    = '0;
        w_strobe_nxt[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_btn_meta <= '0;
      r_btn_sync <= '0;
      r_sw_meta  <= '0;
      r_sw_sync  <= '0;
      for (int i = 0; i < N_BUTTONS; i++) begin
        r_cnt[i] <= '0;
      end
      r_level    <= '0;
      r_strobe   <= '0;
      r_sw_snap  <= '0;
    end else begin
      r_btn_meta <= bus.BUTTONS_RAW;
      r_btn_sync <= r_btn_meta;
      r_sw_meta  <= bus.SWITCHES_RAW;
      r_sw_sync  <= r_sw_meta;
      for (int i = 0; i < N_BUTTONS; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      r_level    <= r_level ^ w_accept;
      r_strobe   <= w_strobe_nxt;
      // Snapshot only with a strobe so switch moves between presses stay invisible.
      if (|w_rise) begin
        r_sw_snap <= r_sw_sync;
      end
    end
  end

  assign bus.BUTTONS   = r_strobe;
  assign bus.SWITCHES  = r_sw_snap;
  assign bus.BTN_LEVEL = r_level;

endmodule

// File: tb/tb_alu_input_conditioner.sv
module tb_alu_input_conditioner;
  localparam int NB = 3;
  localparam int SD = 8;
  localparam int DB = 4;
  localparam int CW = 20;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  alu_input_conditioner_if #(.N_BUTTONS(NB), .SIZEDATA(SD)) bus ();

  alu_input_conditioner #(
    .N_BUTTONS(NB), .SIZEDATA(SD), .DEBOUNCE_CYCLES(DB), .CNT_WIDTH(CW)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int n_run  = 0;
  int n_fail = 0;

  // Reference model: a level flips once the last DB synchronised samples all
  // disagree with it; a 0->1 flip is a press, lowest pressed index strobes.
  logic [NB-1:0] m_q1, m_q2, m_lvl, m_btn, m_nl, m_rise;
  logic [SD-1:0] m_swq1, m_swq2, m_sw;
  logic [NB-1:0] m_hist [DB];
  bit            m_all;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_q1 = '0; m_q2 = '0; m_swq1 = '0; m_swq2 = '0;
      m_lvl = '0; m_btn = '0; m_sw = '0;
      for (int k = 0; k < DB; k++) m_hist[k] = '0;
    end else begin
      for (int k = DB - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = m_q2;
      for (int i = 0; i < NB; i++) begin
        m_all = 1'b1;
        for (int k = 0; k < DB; k++) if (m_hist[k][i] == m_lvl[i]) m_all = 1'b0;
        m_nl[i] = m_all ? ~m_lvl[i] : m_lvl[i];
      end
      m_rise = m_nl & ~m_lvl;
      m_btn  = '0;
      for (int i = 0; i < NB; i++) if (m_rise[i] && m_btn == '0) m_btn[i] = 1'b1;
      if (m_rise != '0) m_sw = m_swq2;
      m_lvl  = m_nl;
      m_q2   = m_q1;   m_q1   = bus.BUTTONS_RAW;
      m_swq2 = m_swq1; m_swq1 = bus.SWITCHES_RAW;
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    bus.BUTTONS_RAW  = '0;
    bus.SWITCHES_RAW = '0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    bus.BUTTONS_RAW  = 3'b111;
    bus.SWITCHES_RAW = 8'hC3;
    repeat (8) @(negedge CLK);
    n_run++;
    if (bus.BUTTONS !== 3'b000) begin
      n_fail++; $display("FAIL reset_buttons: got %b want 000", bus.BUTTONS);
    end
    n_run++;
    if (bus.SWITCHES !== 8'h00) begin
      n_fail++; $display("FAIL reset_switches: got %h want 00", bus.SWITCHES);
    end
    n_run++;
    if (bus.BTN_LEVEL !== 3'b000) begin
      n_fail++; $display("FAIL reset_level: got %b want 000", bus.BTN_LEVEL);
    end
    RST_N = 1'b1;
  endtask

  task automatic test_clean_press();
    int nstb, stb_edge;
    nstb = 0; stb_edge = -1;
    do_reset();
    bus.SWITCHES_RAW = 8'h5A;
    bus.BUTTONS_RAW  = 3'b001;
    for (int e = 1; e <= 20; e++) begin
      @(negedge CLK);
      n_run++;
      if ({bus.BUTTONS, bus.SWITCHES, bus.BTN_LEVEL} !== {m_btn, m_sw, m_lvl}) begin
        n_fail++;
        $display("FAIL clean_model e=%0d: got %b/%h/%b want %b/%h/%b", e,
                 bus.BUTTONS, bus.SWITCHES, bus.BTN_LEVEL, m_btn, m_sw, m_lvl);
      end
      if (e == DB + 1) begin
        n_run++;
        if (bus.BTN_LEVEL !== 3'b000) begin
          n_fail++; $display("FAIL clean_early_level: got %b want 000", bus.BTN_LEVEL);
        end
      end
      if (bus.BUTTONS != 3'b000) begin
        nstb++; stb_edge = e;
        n_run++;
        if (bus.BUTTONS !== 3'b001) begin
          n_fail++; $display("FAIL clean_strobe_val: got %b want 001", bus.BUTTONS);
        end
      end
    end
    n_run++;
    if (nstb != 1 || stb_edge != DB + 2) begin
      n_fail++;
      $display("FAIL clean_strobe_timing: got %0d strobes at edge %0d want 1 at edge %0d",
               nstb, stb_edge, DB + 2);
    end
    n_run++;
    if (bus.SWITCHES !== 8'h5A || bus.BTN_LEVEL !== 3'b001) begin
      n_fail++;
      $display("FAIL clean_hold: got sw=%h lvl=%b want sw=5a lvl=001", bus.SWITCHES, bus.BTN_LEVEL);
    end
  endtask

  task automatic test_bounce();
    int nstb, stb_edge, glitch_bad;
    nstb = 0; stb_edge = -1; glitch_bad = 0;
    do_reset();
    for (int e = 1; e <= 25; e++) begin
      if (e <= 12) bus.BUTTONS_RAW = ((e - 1) % 4 < 3) ? 3'b010 : 3'b000;
      else         bus.BUTTONS_RAW = 3'b010;
      @(negedge CLK);
      n_run++;
      if ({bus.BUTTONS, bus.SWITCHES, bus.BTN_LEVEL} !== {m_btn, m_sw, m_lvl}) begin
        n_fail++;
        $display("FAIL bounce_model e=%0d: got %b/%h/%b want %b/%h/%b", e,
                 bus.BUTTONS, bus.SWITCHES, bus.BTN_LEVEL, m_btn, m_sw, m_lvl);
      end
      if (bus.BUTTONS != 3'b000) begin
        nstb++; stb_edge = e;
        n_run++;
        if (bus.BUTTONS !== 3'b010) begin
          n_fail++; $display("FAIL bounce_strobe_val: got %b want 010", bus.BUTTONS);
        end
      end
    end
    n_run++;
    if (nstb != 1 || stb_edge != 13 + DB + 1) begin
      n_fail++;
      $display("FAIL bounce_strobe_timing: got %0d strobes at edge %0d want 1 at edge %0d",
               nstb, stb_edge, 13 + DB + 1);
    end
    // Two-cycle glitch on button 0 while button 1 stays held.
    for (int e = 1; e <= 12; e++) begin
      bus.BUTTONS_RAW = (e <= 2) ? 3'b011 : 3'b010;
      @(negedge CLK);
      if (bus.BUTTONS != 3'b000 || bus.BTN_LEVEL != 3'b010) glitch_bad++;
    end
    n_run++;
    if (glitch_bad != 0) begin
      n_fail++; $display("FAIL glitch_ignored: got %0d bad cycles want 0", glitch_bad);
    end
  endtask

  task automatic test_simultaneous();
    int nstb;
    logic [NB-1:0] seen;
    nstb = 0; seen = '0;
    do_reset();
    bus.SWITCHES_RAW = 8'h77;
    bus.BUTTONS_RAW  = 3'b101;
    for (int e = 1; e <= 12; e++) begin
      @(negedge CLK);
      n_run++;
      if ({bus.BUTTONS, bus.SWITCHES, bus.BTN_LEVEL} !== {m_btn, m_sw, m_lvl}) begin
        n_fail++;
        $display("FAIL simul_model e=%0d: got %b/%h/%b want %b/%h/%b", e,
                 bus.BUTTONS, bus.SWITCHES, bus.BTN_LEVEL, m_btn, m_sw, m_lvl);
      end
      if (bus.BUTTONS != 3'b000) nstb++;
      seen = seen | bus.BUTTONS;
    end
    n_run++;
    if (nstb != 1 || seen !== 3'b001 || bus.BTN_LEVEL !== 3'b101) begin
      n_fail++;
      $display("FAIL simul_press: got %0d strobes seen=%b lvl=%b want 1 seen=001 lvl=101",
               nstb, seen, bus.BTN_LEVEL);
    end
  endtask

  task automatic test_alu_sequence();
    logic [SD-1:0] exp_sw [3];
    logic [NB-1:0] got_btn [3];
    logic [SD-1:0] got_sw [3];
    int nstb;
    exp_sw = '{8'h0F, 8'h03, 8'h20};
    nstb = 0;
    do_reset();
    for (int op = 0; op < 3; op++) begin
      bus.SWITCHES_RAW = exp_sw[op];
      for (int e = 1; e <= 20; e++) begin
        bus.BUTTONS_RAW = (e <= 10) ? (NB'(1) << op) : '0;
        if (e > 10) bus.SWITCHES_RAW = SD'($urandom);
        @(negedge CLK);
        n_run++;
        if ({bus.BUTTONS, bus.SWITCHES, bus.BTN_LEVEL} !== {m_btn, m_sw, m_lvl}) begin
          n_fail++;
          $display("FAIL alu_model op=%0d e=%0d: got %b/%h/%b want %b/%h/%b", op, e,
                   bus.BUTTONS, bus.SWITCHES, bus.BTN_LEVEL, m_btn, m_sw, m_lvl);
        end
        if (bus.BUTTONS != 3'b000) begin
          if (nstb < 3) begin
            got_btn[nstb] = bus.BUTTONS;
            got_sw[nstb]  = bus.SWITCHES;
          end
          nstb++;
        end
      end
      n_run++;
      if (bus.SWITCHES !== exp_sw[op]) begin
        n_fail++;
        $display("FAIL alu_sw_hold op=%0d: got %h want %h", op, bus.SWITCHES, exp_sw[op]);
      end
    end
    n_run++;
    if (nstb != 3) begin
      n_fail++; $display("FAIL alu_strobe_count: got %0d want 3", nstb);
    end else begin
      for (int op = 0; op < 3; op++) begin
        n_run++;
        if (got_btn[op] !== (NB'(1) << op) || got_sw[op] !== exp_sw[op]) begin
          n_fail++;
          $display("FAIL alu_strobe op=%0d: got %b/%h want %b/%h", op,
                   got_btn[op], got_sw[op], NB'(1) << op, exp_sw[op]);
        end
      end
    end
  endtask

  task automatic test_release_repress();
    int nstb;
    nstb = 0;
    do_reset();
    for (int e = 1; e <= 30; e++) begin
      bus.BUTTONS_RAW = (e <= 10 || e > 20) ? 3'b001 : 3'b000;
      @(negedge CLK);
      if (bus.BUTTONS == 3'b001) nstb++;
      if (e == 10 + DB + 1) begin
        n_run++;
        if (bus.BTN_LEVEL !== 3'b001) begin
          n_fail++; $display("FAIL release_early: got %b want 001", bus.BTN_LEVEL);
        end
      end
      if (e == 10 + DB + 2) begin
        n_run++;
        if (bus.BTN_LEVEL !== 3'b000 || bus.BUTTONS !== 3'b000) begin
          n_fail++;
          $display("FAIL release_fall: got lvl=%b btn=%b want 000/000", bus.BTN_LEVEL, bus.BUTTONS);
        end
      end
    end
    n_run++;
    if (nstb != 2) begin
      n_fail++; $display("FAIL repress_count: got %0d want 2", nstb);
    end
  endtask

  task automatic test_reset_mid();
    int nstb, stb_edge;
    nstb = 0; stb_edge = -1;
    do_reset();
    bus.SWITCHES_RAW = 8'hAA;
    bus.BUTTONS_RAW  = 3'b010;
    repeat (8) @(negedge CLK);
    bus.BUTTONS_RAW = 3'b011;
    repeat (4) @(negedge CLK);       // button 0 two cycles into its count
    #2 RST_N = 1'b0;
    #1;
    n_run++;
    if ({bus.BUTTONS, bus.SWITCHES, bus.BTN_LEVEL} !== {3'b000, 8'h00, 3'b000}) begin
      n_fail++;
      $display("FAIL mid_reset_clear: got %b/%h/%b want 000/00/000",
               bus.BUTTONS, bus.SWITCHES, bus.BTN_LEVEL);
    end
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(negedge CLK);
      n_run++;
      if ({bus.BUTTONS, bus.SWITCHES, bus.BTN_LEVEL} !== {m_btn, m_sw, m_lvl}) begin
        n_fail++;
        $display("FAIL mid_reset_model e=%0d: got %b/%h/%b want %b/%h/%b", e,
                 bus.BUTTONS, bus.SWITCHES, bus.BTN_LEVEL, m_btn, m_sw, m_lvl);
      end
      if (bus.BUTTONS != 3'b000) begin nstb++; stb_edge = e; end
    end
    n_run++;
    if (nstb != 1 || stb_edge != DB + 2 || bus.BTN_LEVEL !== 3'b011 || bus.SWITCHES !== 8'hAA) begin
      n_fail++;
      $display("FAIL mid_reset_restart: got %0d strobes at %0d lvl=%b sw=%h want 1 at %0d lvl=011 sw=aa",
               nstb, stb_edge, bus.BTN_LEVEL, bus.SWITCHES, DB + 2);
    end
  endtask

  task automatic test_random();
    int nerr;
    nerr = 0;
    do_reset();
    for (int e = 1; e <= 800; e++) begin
      if ($urandom_range(5) == 0) bus.BUTTONS_RAW[$urandom_range(NB - 1)] ^= 1'b1;
      if ($urandom_range(3) == 0) bus.SWITCHES_RAW = SD'($urandom);
      @(negedge CLK);
      n_run++;
      if ({bus.BUTTONS, bus.SWITCHES, bus.BTN_LEVEL} !== {m_btn, m_sw, m_lvl}) begin
        n_fail++;
        if (nerr < 10)
          $display("FAIL random_model e=%0d: got %b/%h/%b want %b/%h/%b", e,
                   bus.BUTTONS, bus.SWITCHES, bus.BTN_LEVEL, m_btn, m_sw, m_lvl);
        nerr++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_alu_sequence();
    test_release_repress();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
